// File: rtl/cache_pkg.sv
// Shared geometry, tag-field positions and FSM/owner encodings for the dcache
// flush sequencer and its memory-port arbiter.
package cache_pkg;

    localparam int NUM_SETS  = 16;
    localparam int NUM_WAYS  = 2;
    localparam int LINE_W    = 256;
    localparam int TAG_W     = 25;
    localparam int ADDR_W    = 32;
    localparam int IDX_W     = $clog2(NUM_SETS);
    localparam int WAY_W     = $clog2(NUM_WAYS);
    localparam int CNT_W     = WAY_W + IDX_W;
    localparam int VALID_BIT = 24;
    localparam int DIRTY_BIT = 23;
    localparam int ATAG_W    = 23;
    localparam int OFFSET_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BUS,
        ST_CHECK,
        ST_WB,
        ST_CLEAN,
        ST_DONE
    } flush_state_e;

    typedef enum logic {
        OWN_DCACHE,
        OWN_FLUSH
    } owner_e;

    // Line base address rebuilt from the stored address tag and the set index.
    function automatic logic [ADDR_W-1:0] wb_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
        return {tag[ATAG_W-1:0], idx, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/mem_port_mux.sv
// Owns the single Data_Memory port: an owner register plus the request mux
// and ack steering between the dcache controller and the flush write-backs.
module mem_port_mux
    import cache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              acquire,
    input  logic              release_bus,
    output logic              dc_idle,
    input  logic              flush_enable,
    input  logic [ADDR_W-1:0] flush_addr,
    input  logic [LINE_W-1:0] flush_data,
    input  logic              dc_mem_enable_i,
    input  logic              dc_mem_write_i,
    input  logic [ADDR_W-1:0] dc_mem_addr_i,
    input  logic [LINE_W-1:0] dc_mem_data_i,
    output logic              dc_mem_ack_o,
    output logic [LINE_W-1:0] dc_mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i
);

    owner_e owner_q;

    // The ack cycle is the last cycle of a dcache transaction, so the port can
    // change hands at the edge that ends it.
    assign dc_idle       = !dc_mem_enable_i || mem_ack_i;
    assign dc_mem_data_o = mem_data_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q <= OWN_DCACHE;
        end else if (release_bus) begin
            owner_q <= OWN_DCACHE;
        end else if (acquire && dc_idle) begin
            owner_q <= OWN_FLUSH;
        end
    end

    always_comb begin
        mem_enable_o = dc_mem_enable_i;
        mem_write_o  = dc_mem_write_i;
        mem_addr_o   = dc_mem_addr_i;
        mem_data_o   = dc_mem_data_i;
        dc_mem_ack_o = mem_ack_i;
        if (owner_q == OWN_FLUSH) begin
            mem_enable_o = flush_enable;
            mem_write_o  = 1'b1;
            mem_addr_o   = flush_addr;
            mem_data_o   = flush_data;
            dc_mem_ack_o = 1'b0;
        end
    end

endmodule

// File: rtl/dcache_flush_arbiter.sv
// Write-back flush sequencer: walks all {way, idx} entries, writes each
// valid+dirty line to Data_Memory and clears its dirty bit while stalling the CPU.
module dcache_flush_arbiter
    import cache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_req_i,
    output logic              flush_busy_o,
    output logic              flush_done_o,
    output logic              cpu_stall_o,
    output logic [IDX_W-1:0]  sram_idx_o,
    output logic              sram_way_o,
    input  logic [TAG_W-1:0]  sram_tag_i,
    input  logic [LINE_W-1:0] sram_data_i,
    output logic              sram_wr_o,
    output logic [TAG_W-1:0]  sram_tag_o,
    input  logic              dc_mem_enable_i,
    input  logic              dc_mem_write_i,
    input  logic [ADDR_W-1:0] dc_mem_addr_i,
    input  logic [LINE_W-1:0] dc_mem_data_i,
    output logic              dc_mem_ack_o,
    output logic [LINE_W-1:0] dc_mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i
);

    flush_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [TAG_W-1:0]  tag_q;
    logic [LINE_W-1:0] buf_q;
    logic              hit;
    logic              last;
    logic              walking;
    logic              dc_idle;
    logic              acquire;
    logic              release_bus;

    assign hit  = sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT];
    assign last = (cnt_q == {CNT_W{1'b1}});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The counter advances on leaving an entry (clean CHECK or CLEAN), so the
    // wrap from 31 back to 0 leaves it ready for the next flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            tag_q <= '0;
            buf_q <= '0;
        end else begin
            case (state_q)
                ST_CHECK: begin
                    if (hit) begin
                        tag_q <= sram_tag_i;
                        buf_q <= sram_data_i;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_CLEAN: cnt_q <= cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_req_i) begin
                    state_d = dc_idle ? ST_CHECK : ST_WAIT_BUS;
                end
            end
            ST_WAIT_BUS: begin
                if (dc_idle) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (hit)       state_d = ST_WB;
                else if (last) state_d = ST_DONE;
            end
            ST_WB: begin
                if (mem_ack_i) state_d = ST_CLEAN;
            end
            ST_CLEAN: state_d = last ? ST_DONE : ST_CHECK;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        walking      = (state_q == ST_CHECK) || (state_q == ST_WB) || (state_q == ST_CLEAN);
        flush_busy_o = (state_q != ST_IDLE);
        cpu_stall_o  = flush_busy_o;
        flush_done_o = (state_q == ST_DONE);
        sram_wr_o    = (state_q == ST_CLEAN);
        sram_idx_o   = walking ? cnt_q[IDX_W-1:0] : '0;
        sram_way_o   = walking ? cnt_q[CNT_W-1] : 1'b0;
        sram_tag_o   = '0;
        if (state_q == ST_CLEAN) begin
            sram_tag_o            = tag_q;
            sram_tag_o[DIRTY_BIT] = 1'b0;
        end
        acquire     = ((state_q == ST_IDLE) && flush_req_i) || (state_q == ST_WAIT_BUS);
        release_bus = (state_q == ST_DONE);
    end

    mem_port_mux u_mux (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .acquire         (acquire),
        .release_bus     (release_bus),
        .dc_idle         (dc_idle),
        .flush_enable    (state_q == ST_WB),
        .flush_addr      (wb_addr(tag_q, cnt_q[IDX_W-1:0])),
        .flush_data      (buf_q),
        .dc_mem_enable_i (dc_mem_enable_i),
        .dc_mem_write_i  (dc_mem_write_i),
        .dc_mem_addr_i   (dc_mem_addr_i),
        .dc_mem_data_i   (dc_mem_data_i),
        .dc_mem_ack_o    (dc_mem_ack_o),
        .dc_mem_data_o   (dc_mem_data_o),
        .mem_enable_o    (mem_enable_o),
        .mem_write_o     (mem_write_o),
        .mem_addr_o      (mem_addr_o),
        .mem_data_o      (mem_data_o),
        .mem_ack_i       (mem_ack_i),
        .mem_data_i      (mem_data_i)
    );

endmodule

// File: tb/tb_dcache_flush_arbiter.sv
// Scoreboard bench for dcache_flush_arbiter: directed cache images and dcache
// traffic, expected bus/SRAM/done events queued and checked by a monitor.
module tb_dcache_flush_arbiter;
    import cache_pkg::*;

    localparam int EV_DCACK  = 0;
    localparam int EV_MEMWR  = 1;
    localparam int EV_SRAMWR = 2;
    localparam int EV_DONE   = 3;
    localparam logic [LINE_W-1:0] RD_DATA  = {32'h0000_1001, {5{32'h1234_5678}}, 32'h0000_F00F};
    localparam logic [LINE_W-1:0] ECFA     = {16{16'hECFA}};
    localparam logic [LINE_W-1:0] LINE_A   = {8{32'hA5A5_0005}};
    localparam logic [LINE_W-1:0] LINE_B   = {8{32'hB00B_0102}};
    localparam logic [LINE_W-1:0] LINE_DEA = {8{32'hDEAD_0001}};

    typedef struct {
        int               kind;
        logic [31:0]      a;
        logic [LINE_W-1:0] d;
    } ev_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_req_i;
    logic              flush_busy_o, flush_done_o, cpu_stall_o;
    logic [IDX_W-1:0]  sram_idx_o;
    logic              sram_way_o;
    logic [TAG_W-1:0]  sram_tag_i;
    logic [LINE_W-1:0] sram_data_i;
    logic              sram_wr_o;
    logic [TAG_W-1:0]  sram_tag_o;
    logic              dc_mem_enable_i, dc_mem_write_i;
    logic [ADDR_W-1:0] dc_mem_addr_i;
    logic [LINE_W-1:0] dc_mem_data_i;
    logic              dc_mem_ack_o;
    logic [LINE_W-1:0] dc_mem_data_o;
    logic              mem_enable_o, mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_i;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   req_cyc = 0;
    ev_t  sb[$];

    logic [TAG_W-1:0]  tag_mem  [2][16];
    logic [LINE_W-1:0] data_mem [2][16];
    logic              ld_en, ld_clear, ld_way;
    logic [3:0]        ld_idx;
    logic [TAG_W-1:0]  ld_tag;
    logic [3:0]        lat_cnt;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    dcache_flush_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_req_i(flush_req_i),
        .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o), .cpu_stall_o(cpu_stall_o),
        .sram_idx_o(sram_idx_o), .sram_way_o(sram_way_o), .sram_tag_i(sram_tag_i),
        .sram_data_i(sram_data_i), .sram_wr_o(sram_wr_o), .sram_tag_o(sram_tag_o),
        .dc_mem_enable_i(dc_mem_enable_i), .dc_mem_write_i(dc_mem_write_i),
        .dc_mem_addr_i(dc_mem_addr_i), .dc_mem_data_i(dc_mem_data_i),
        .dc_mem_ack_o(dc_mem_ack_o), .dc_mem_data_o(dc_mem_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
    );

    // Cache SRAM image: combinational read, tag written by the DUT or preloaded.
    assign sram_tag_i  = tag_mem[sram_way_o][sram_idx_o];
    assign sram_data_i = data_mem[sram_way_o][sram_idx_o];

    always @(posedge clk_i) begin
        if (ld_clear) begin
            for (int w = 0; w < 2; w++)
                for (int i = 0; i < 16; i++) tag_mem[w][i] <= '0;
        end else if (ld_en) begin
            tag_mem[ld_way][ld_idx] <= ld_tag;
        end else if (sram_wr_o) begin
            tag_mem[sram_way_o][sram_idx_o] <= sram_tag_o;
        end
    end

    // Data_Memory: ack pulses in the 11th cycle of a held request.
    assign mem_data_i = (mem_addr_o == 32'h0000_0400) ? RD_DATA : '0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_ack_i <= 1'b0;
            lat_cnt   <= '0;
        end else begin
            mem_ack_i <= 1'b0;
            if (mem_enable_o && !mem_ack_i) begin
                if (lat_cnt == 4'd9) begin
                    mem_ack_i <= 1'b1;
                    lat_cnt   <= '0;
                end else begin
                    lat_cnt <= lat_cnt + 4'd1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                               input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pushEv(input int kind, input logic [31:0] a, input logic [LINE_W-1:0] d);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] sramKey(input logic [3:0] idx, input logic way,
                                            input logic [TAG_W-1:0] tag);
        return {2'b00, idx, way, tag};
    endfunction

    task automatic handleEv(input int kind, input logic [31:0] a, input logic [LINE_W-1:0] d);
        ev_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_event: got kind %0d key %0h, expected none", kind, a);
        end else begin
            e = sb.pop_front();
            checkOutput("event_kind", LINE_W'(kind), LINE_W'(e.kind));
            checkOutput("event_key", LINE_W'(a), LINE_W'(e.a));
            if (e.kind == EV_MEMWR || e.kind == EV_DCACK)
                checkOutput("event_data", d, e.d);
        end
    endtask

    // Monitor: one sample per cycle, shortly after the active edge.
    always begin
        @(posedge clk_i);
        #1;
        if (!rst_i) begin
            if (dc_mem_ack_o) handleEv(EV_DCACK, 32'h0, dc_mem_data_o);
            if (mem_enable_o && mem_write_o && mem_ack_i) handleEv(EV_MEMWR, mem_addr_o, mem_data_o);
            if (sram_wr_o) handleEv(EV_SRAMWR, sramKey(sram_idx_o, sram_way_o, sram_tag_o), '0);
            if (flush_done_o) handleEv(EV_DONE, 32'(cyc - req_cyc), '0);
        end
    end

    task automatic applyStimulus();
        @(negedge clk_i);
        flush_req_i = 1'b1;
        req_cyc     = cyc;
        @(negedge clk_i);
        flush_req_i = 1'b0;
    endtask

    task automatic loadTag(input logic way, input logic [3:0] idx, input logic [TAG_W-1:0] tag);
        @(negedge clk_i);
        ld_en = 1'b1; ld_way = way; ld_idx = idx; ld_tag = tag;
        @(negedge clk_i);
        ld_en = 1'b0;
    endtask

    task automatic clearTags();
        @(negedge clk_i);
        ld_clear = 1'b1;
        @(negedge clk_i);
        ld_clear = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while (flush_busy_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput(name, LINE_W'(flush_busy_o), LINE_W'(0));
        @(negedge clk_i);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; flush_req_i = 1'b0;
        dc_mem_enable_i = 1'b0; dc_mem_write_i = 1'b0; dc_mem_addr_i = '0; dc_mem_data_i = '0;
        ld_en = 1'b0; ld_clear = 1'b1; ld_way = 1'b0; ld_idx = '0; ld_tag = '0;
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 16; i++) data_mem[w][i] = '0;
        repeat (3) @(negedge clk_i);
        checkOutput("rst_busy", LINE_W'(flush_busy_o), LINE_W'(0));
        checkOutput("rst_done", LINE_W'(flush_done_o), LINE_W'(0));
        checkOutput("rst_stall", LINE_W'(cpu_stall_o), LINE_W'(0));
        checkOutput("rst_sram_wr", LINE_W'(sram_wr_o), LINE_W'(0));
        checkOutput("rst_sram_idx", LINE_W'({sram_way_o, sram_idx_o}), LINE_W'(0));
        checkOutput("rst_mem_en", LINE_W'(mem_enable_o), LINE_W'(0));
        rst_i = 1'b0; ld_clear = 1'b0;
        $display("[TB] reset released");

        // Fully clean cache; a second request mid-flush must be ignored.
        pushEv(EV_DONE, 32'd33, '0);
        applyStimulus();
        repeat (9) @(negedge clk_i);
        checkOutput("clean_stall", LINE_W'(cpu_stall_o), LINE_W'(1));
        checkOutput("clean_idx9", LINE_W'({sram_way_o, sram_idx_o}), LINE_W'(9));
        flush_req_i = 1'b1;
        @(negedge clk_i);
        flush_req_i = 1'b0;
        waitIdle("clean_timeout", 100);

        // One dirty line at set 3 way 1.
        loadTag(1'b1, 4'd3, 25'h1800001);
        data_mem[1][3] = ECFA;
        pushEv(EV_MEMWR, 32'h0000_0260, ECFA);
        pushEv(EV_SRAMWR, sramKey(4'd3, 1'b1, 25'h1000001), '0);
        pushEv(EV_DONE, 32'd45, '0);
        applyStimulus();
        waitIdle("one_dirty_timeout", 200);
        checkOutput("one_dirty_tag", LINE_W'(tag_mem[1][3]), LINE_W'(25'h1000001));

        // Valid-clean and dirty-invalid entries produce no traffic.
        clearTags();
        loadTag(1'b0, 4'd0, 25'h1000000);
        loadTag(1'b1, 4'd0, 25'h0800005);
        pushEv(EV_DONE, 32'd33, '0);
        applyStimulus();
        waitIdle("no_wb_timeout", 100);
        checkOutput("no_wb_tag0", LINE_W'(tag_mem[0][0]), LINE_W'(25'h1000000));
        checkOutput("no_wb_tag1", LINE_W'(tag_mem[1][0]), LINE_W'(25'h0800005));

        // Flush requested while a dcache read is in flight.
        clearTags();
        pushEv(EV_DCACK, 32'h0, RD_DATA);
        pushEv(EV_DONE, 32'd40, '0);
        @(negedge clk_i);
        dc_mem_enable_i = 1'b1; dc_mem_write_i = 1'b0; dc_mem_addr_i = 32'h0000_0400;
        repeat (3) @(negedge clk_i);
        flush_req_i = 1'b1;
        req_cyc     = cyc;
        @(negedge clk_i);
        flush_req_i = 1'b0;
        checkOutput("pend_stall", LINE_W'(cpu_stall_o), LINE_W'(1));
        checkOutput("pend_dc_owns", LINE_W'(mem_enable_o), LINE_W'(1));
        for (int n = 0; n < 30 && !dc_mem_ack_o; n++) @(negedge clk_i);
        checkOutput("pend_dc_ack", LINE_W'(dc_mem_ack_o), LINE_W'(1));
        dc_mem_enable_i = 1'b0;
        waitIdle("pend_timeout", 100);

        // Two dirty lines, visited way-major.
        loadTag(1'b1, 4'd2, 25'h1C00003);
        loadTag(1'b0, 4'd5, 25'h1800010);
        data_mem[1][2] = LINE_B;
        data_mem[0][5] = LINE_A;
        pushEv(EV_MEMWR, 32'h0000_20A0, LINE_A);
        pushEv(EV_SRAMWR, sramKey(4'd5, 1'b0, 25'h1000010), '0);
        pushEv(EV_MEMWR, 32'h8000_0640, LINE_B);
        pushEv(EV_SRAMWR, sramKey(4'd2, 1'b1, 25'h1400003), '0);
        pushEv(EV_DONE, 32'd57, '0);
        applyStimulus();
        waitIdle("two_dirty_timeout", 200);

        // Reset in the middle of a write-back abandons it.
        clearTags();
        loadTag(1'b0, 4'd0, 25'h1800002);
        data_mem[0][0] = LINE_DEA;
        applyStimulus();
        repeat (3) @(negedge clk_i);
        checkOutput("wb_active", LINE_W'(mem_enable_o), LINE_W'(1));
        #2 rst_i = 1'b1;
        #1;
        checkOutput("async_mem_en", LINE_W'(mem_enable_o), LINE_W'(0));
        checkOutput("async_busy", LINE_W'(flush_busy_o), LINE_W'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("abandon_tag", LINE_W'(tag_mem[0][0]), LINE_W'(25'h1800002));
        pushEv(EV_MEMWR, 32'h0000_0400, LINE_DEA);
        pushEv(EV_SRAMWR, sramKey(4'd0, 1'b0, 25'h1000002), '0);
        pushEv(EV_DONE, 32'd45, '0);
        applyStimulus();
        waitIdle("rewrite_timeout", 200);
        checkOutput("rewrite_tag", LINE_W'(tag_mem[0][0]), LINE_W'(25'h1000002));

        repeat (3) @(negedge clk_i);
        checkOutput("scoreboard_drained", LINE_W'(sb.size()), LINE_W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_flush_arbiter.md
Name: dcache_flush_arbiter

Overview:
Hardware write-back flush sequencer for the 2-way, 16-set data cache. It also arbitrates the single Data_Memory port between the dcache miss controller and its own write-backs. On request it walks every cache entry, writes each valid+dirty line back to memory and clears its dirty bit, stalling the CPU meanwhile. It sits between the dcache controller / dcache SRAM and Data_Memory, replacing the bench-side hierarchical flush.

Parameters:
NUM_SETS, 16, cache sets; IDX_W = log2(NUM_SETS)
NUM_WAYS, 2, ways per set
LINE_W, 256, cache line / memory word width in bits
TAG_W, 25, SRAM tag entry width: bit24 valid, bit23 dirty, bits[22:0] address tag
ADDR_W, 32, byte address width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
flush_req_i  in  1  start flush (sampled in IDLE only)
flush_busy_o  out  1  high from accept until DONE, inclusive
flush_done_o  out  1  one-cycle pulse at completion
cpu_stall_o  out  1  pipeline stall while flush owns the cache
sram_idx_o  out  IDX_W  SRAM set index during flush
sram_way_o  out  1  SRAM way during flush
sram_tag_i  in  TAG_W  combinational tag read of (idx,way)
sram_data_i  in  LINE_W  combinational data read of (idx,way)
sram_wr_o  out  1  tag write strobe (dirty clear)
sram_tag_o  out  TAG_W  tag write value
dc_mem_enable_i  in  1  dcache controller memory request
dc_mem_write_i  in  1  dcache request is a write
dc_mem_addr_i  in  ADDR_W  dcache request address
dc_mem_data_i  in  LINE_W  dcache write data
dc_mem_ack_o  out  1  ack forwarded to dcache
dc_mem_data_o  out  LINE_W  read data forwarded to dcache
mem_enable_o  out  1  Data_Memory enable
mem_write_o  out  1  Data_Memory write
mem_addr_o  out  ADDR_W  Data_Memory address
mem_data_o  out  LINE_W  Data_Memory write data
mem_ack_i  in  1  Data_Memory ack (one-cycle pulse)
mem_data_i  in  LINE_W  Data_Memory read data

Behaviour:
- Reset (async): state IDLE, owner=DCACHE, entry counter 0. All outputs 0 except pass-through paths. mem_enable_o drops immediately. A reset mid-write-back abandons it with no SRAM write.
- Memory handshake: requester holds enable, write, addr and data stable until the ack cycle. Enable drops the cycle after ack. The design is latency-independent; the model latency is 10 cycles.
- Arbitration: owner register, DCACHE or FLUSH. When owner=DCACHE, mem_* = dc_mem_* and dc_mem_ack_o/dc_mem_data_o = mem_ack_i/mem_data_i. When owner=FLUSH, dc_mem_ack_o=0.
- Ownership switches only when the bus is idle: no enable, or the cycle after ack.
- If flush_req_i and dc_mem_enable_i are both high in IDLE, the dcache wins. The flush is latched pending and starts once the transaction completes.
- FSM: IDLE -> WAIT_BUS (pending, dcache transaction in flight) -> CHECK -> [WB -> CLEAN] -> NEXT -> ... -> DONE -> IDLE.
- CHECK: one cycle per entry. Samples sram_tag_i. If bit24 and bit23 are both set, it latches sram_data_i into the write-back buffer and goes to WB. Otherwise it goes to NEXT.
- WB: mem_enable_o=1, mem_write_o=1, mem_addr_o = {tag[22:0], idx, 5'b0}, mem_data_o = buffer. Stays until mem_ack_i.
- CLEAN: one cycle. sram_wr_o=1, sram_tag_o = sampled tag with bit23 cleared; valid and tag are preserved.
- Walk order is way-major: way 0 idx 0..15, then way 1 idx 0..15. The counter is {way, idx} and is 5 bits wide. Wrap from 31 goes to DONE.
- NEXT is folded into CHECK/CLEAN (the counter increments on exit), so a clean entry costs exactly 1 cycle.
- cpu_stall_o and flush_busy_o are high from WAIT_BUS/CHECK through DONE.
- Fully clean cache, idle bus: flush_done_o pulses 33 cycles after flush_req_i is sampled (32 CHECK + DONE).
- flush_req_i while busy is ignored, not queued. A level held through DONE retriggers a new flush.
- sram_idx_o and sram_way_o are 0 and sram_wr_o is 0 outside a flush.

Decomposition:
- Shared package cache_pkg: NUM_SETS, NUM_WAYS, LINE_W, TAG_W, VALID_BIT=24, DIRTY_BIT=23, the flush state enum, and the owner enum.
- One sub-module, mem_port_mux: the owner register plus the combinational mux and ack steering.
- The FSM and counter stay in the top level.

Test Plan:
- All tags 0, flush_req_i pulse -> no mem_enable_o, no sram_wr_o, flush_done_o exactly 33 cycles later, cpu_stall_o high throughout.
- Set 3 way 1 tag=25'h1800001, data=256'hECFA...ECFA -> one write at mem_addr_o=32'h00000260 (memory[19]=ECFA...), then sram_tag_o=25'h1000001 at idx 3 way 1.
- Set 0 way 0 tag=25'h1000000 (valid, clean) and set 0 way 1 tag=25'h0800005 (dirty, invalid) -> no memory writes.
- dc_mem_enable_i read of 32'h400 in flight, flush_req_i raised mid-transaction -> dcache receives ack and data 256'h0000_1001...F00F; flush CHECK starts the cycle after the ack cycle; no dc_mem_ack_o during flush.
- Two dirty lines with 10-cycle memory -> done at 33 + 2×(11+1) cycles; entries visited in way-major order.
- rst_i asserted during WB -> mem_enable_o=0 asynchronously, flush_busy_o=0, dirty bit unchanged; a new flush rewrites the line.
